// File: rtl/joypad_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : joypad_ctrl_pkg
// Description : Shared GameBoy constants. Holds the P1/JOYP register address,
//               the button-index enum that fixes the bit order of the
//               internal button vectors, and the helper that forms the P1
//               low nibble from the select bits and the debounced levels.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package joypad_ctrl_pkg;

  // P1 / JOYP register address on the CPU bus.
  localparam logic [15:0] c_P1_ADDR = 16'hFF00;

  localparam int c_NUM_BTNS = 8;

  // Bit positions of each button inside the 8-bit button vectors.
  // Action keys occupy [3:0] in P1 read order {start, select, b, a}.
  // Direction keys occupy [7:4] in P1 read order {down, up, left, right}.
  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_RIGHT  = 3'd4,
    BTN_LEFT   = 3'd5,
    BTN_UP     = 3'd6,
    BTN_DOWN   = 3'd7
  } btn_idx_e;

  // P1 low nibble: a selected group (select bit low) contributes its
  // active-low levels; unselected groups read as all ones, so the groups
  // combine with a bitwise AND.
  function automatic logic [3:0] p1_nibble(
    input logic [1:0] sel,
    input logic [7:0] stable_n
  );
    logic [3:0] nib;
    nib = 4'hF;
    if (!sel[1]) begin
      nib = nib & stable_n[3:0];
    end
    if (!sel[0]) begin
      nib = nib & stable_n[7:4];
    end
    return nib;
  endfunction

endpackage : joypad_ctrl_pkg
`default_nettype wire

// File: rtl/joypad_debounce.sv
`default_nettype none
// ============================================================================
// Module      : joypad_debounce
// Description : One button's input conditioning: 2-flop synchronizer
//               followed (when JOYPAD_DEBOUNCE_EN is defined) by a
//               consecutive-cycle debounce filter. Without the macro the
//               synchronized level is passed straight through.
// Parameters  : DEBOUNCE_CYCLES - cycles a new level must persist (1..32767)
// Ports       : cpu_clk    in  clock
//               rst        in  async active-high reset
//               i_raw_n    in  raw active-low button level (asynchronous)
//               o_stable_n out accepted active-low level
// Config      : JOYPAD_DEBOUNCE_EN - enables the debounce filter
// Revision    : 1.0 - initial release
// ============================================================================
module joypad_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic cpu_clk,
  input  logic rst,
  input  logic i_raw_n,
  output logic o_stable_n
);

  generate
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 32767) begin : g_bad_param
      $error("joypad_debounce: DEBOUNCE_CYCLES out of range 1..32767");
    end
  endgenerate

  logic r_sync1;
  logic r_sync2;

  // Released (1) is the reset level so nothing looks pressed out of reset.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_raw_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef JOYPAD_DEBOUNCE_EN
  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_stable;

  // The counter tracks how many consecutive cycles the synchronized level
  // has disagreed with the accepted level. Acceptance happens on the edge
  // that would complete the DEBOUNCE_CYCLES-th disagreeing cycle, and the
  // counter returns to 0 there, so it never wraps.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b1;
    end else if (r_sync2 == r_stable) begin
      r_cnt    <= '0;
    end else if (r_cnt == c_CNT_LAST) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign o_stable_n = r_stable;
`else
  assign o_stable_n = r_sync2;
`endif

endmodule : joypad_debounce
`default_nettype wire

// File: rtl/joypad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : joypad_ctrl
// Description : GameBoy P1/JOYP joypad register. Conditions eight raw
//               active-low buttons, holds the two P1 select bits written
//               by the CPU, presents {2'b11, sel, nibble} at 16'hFF00 and
//               pulses joypad_irq once for any high-to-low nibble change.
// Parameters  : DEBOUNCE_CYCLES - debounce length in cpu_clk cycles
// Ports       : cpu_clk          in   clock (4.19 MHz)
//               rst              in   async active-high reset
//               joypad_<button>  in   raw active-low button levels
//               addr[15:0]       in   CPU address
//               data_in[7:0]     in   CPU write data (bits 5:4 used)
//               we               in   CPU write strobe
//               data_out[7:0]    out  P1 read data, 0 off-address
//               joypad_irq       out  one-cycle interrupt request
// Config      : JOYPAD_DEBOUNCE_EN - enables per-button debounce filter
// Revision    : 1.0 - initial release
// ============================================================================
module joypad_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        joypad_up,
  input  logic        joypad_down,
  input  logic        joypad_left,
  input  logic        joypad_right,
  input  logic        joypad_a,
  input  logic        joypad_b,
  input  logic        joypad_start,
  input  logic        joypad_select,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  input  logic        we,
  output logic [7:0]  data_out,
  output logic        joypad_irq
);

  import joypad_ctrl_pkg::*;

  logic [c_NUM_BTNS-1:0] w_raw_n;
  logic [c_NUM_BTNS-1:0] w_stable_n;
  logic [3:0]            w_nibble;
  logic                  w_p1_sel;
  logic                  w_fall;
  logic                  w_unused_din;

  logic [1:0]            r_sel;
  logic [3:0]            r_nibble_q;
  logic                  r_irq;

  // Pack the buttons in enum order so the P1 groups are plain slices.
  always_comb begin
    w_raw_n             = '1;
    w_raw_n[BTN_A]      = joypad_a;
    w_raw_n[BTN_B]      = joypad_b;
    w_raw_n[BTN_SELECT] = joypad_select;
    w_raw_n[BTN_START]  = joypad_start;
    w_raw_n[BTN_RIGHT]  = joypad_right;
    w_raw_n[BTN_LEFT]   = joypad_left;
    w_raw_n[BTN_UP]     = joypad_up;
    w_raw_n[BTN_DOWN]   = joypad_down;
  end

  generate
    for (genvar gi = 0; gi < c_NUM_BTNS; gi++) begin : g_btn
      joypad_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
        .cpu_clk    (cpu_clk),
        .rst        (rst),
        .i_raw_n    (w_raw_n[gi]),
        .o_stable_n (w_stable_n[gi])
      );
    end
  endgenerate

  assign w_p1_sel = (addr == c_P1_ADDR);

  // Only the select bits of a P1 write are writable.
  assign w_unused_din = &{data_in[7:6], data_in[3:0]};

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      r_sel <= 2'b11;
    end else if (we && w_p1_sel) begin
      r_sel <= data_in[5:4];
    end
  end

  assign w_nibble = p1_nibble(r_sel, w_stable_n);

  assign data_out = w_p1_sel ? {2'b11, r_sel, w_nibble} : 8'h00;

  // A falling edge is any bit that was 1 in the held nibble and is 0 in the
  // value being captured. Select writes that expose a held button show up
  // here the same way as a fresh press.
  assign w_fall = |(r_nibble_q & ~w_nibble);

  // r_irq rises on the same edge that nibble_q takes the new value, so the
  // pulse occupies the cycle right after the capture.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      r_nibble_q <= 4'hF;
      r_irq      <= 1'b0;
    end else begin
      r_nibble_q <= w_nibble;
      r_irq      <= w_fall;
    end
  end

  assign joypad_irq = r_irq;

endmodule : joypad_ctrl
`default_nettype wire

// File: doc/joypad_ctrl.md
JOYPAD_CTRL -- requirements
Module: joypad_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20000, meaning consecutive cpu_clk cycles a raw level must persist before acceptance (range 1..32767).
REQ-002 SHALL have port cpu_clk  input  1  sole clock (4.19 MHz CPU clock).
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports joypad_up, joypad_down, joypad_left, joypad_right, joypad_a, joypad_b, joypad_start, joypad_select  input  1 each  raw button levels, active-low (0 = pressed), asynchronous to cpu_clk.
REQ-005 SHALL have port addr  input  16  CPU bus address.
REQ-006 SHALL have port data_in  input  8  CPU write data.
REQ-007 SHALL have port we  input  1  CPU write strobe, one cycle.
REQ-008 SHALL have port data_out  output  8  read data, 8'h00 when addr != 16'hFF00.
REQ-009 SHALL have port joypad_irq  output  1  one-cycle joypad interrupt request pulse.

Function
REQ-010 SHALL pass each joypad input through a 2-flop synchronizer, both flops reset to 1.
REQ-011 SHALL maintain a stable level per button; stable changes only after the synchronized level differs from stable for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement clears that button's counter to 0.
REQ-012 SHALL hold P1 select bits sel[1:0] (P1 bits 5:4); on we=1 and addr=16'hFF00, sel <= data_in[5:4] at that clock edge; data_in bits 7:6 and 3:0 ignored.
REQ-013 SHALL form nibble[3:0] combinationally: sel[1]=0 (P15) contributes {start, select, b, a}; sel[0]=0 (P14) contributes {down, up, left, right}; both low -> bitwise AND of both groups; both high -> 4'hF.
REQ-014 SHALL drive data_out = {2'b11, sel, nibble} combinationally whenever addr=16'hFF00, regardless of we.
REQ-015 SHALL register nibble each cycle into nibble_q (reset 4'hF).
REQ-016 SHALL assert joypad_irq for exactly one cycle, in the cycle after nibble_q captures a value having any bit 1->0 relative to its previous value; multiple falling bits in one cycle produce one pulse.
REQ-017 SHALL treat a select write that exposes an already-pressed button as a falling edge (irq fires).
REQ-018 SHALL, on simultaneous select write and debounce acceptance in one cycle, apply both; nibble on the next cycle reflects new sel and new stable level.
REQ-019 SHALL produce no irq on 0->1 (release) transitions.
REQ-020 SHALL saturate nothing: debounce counter width is ceil(log2(DEBOUNCE_CYCLES+1)), never wraps because it clears on acceptance.

Reset
REQ-021 SHALL on rst=1 asynchronously set: synchronizers 1, stable levels 1, counters 0, sel 2'b11, nibble_q 4'hF, joypad_irq 0; data_out then reads 8'hFF at 16'hFF00.
REQ-022 SHALL abort any in-progress debounce on reset mid-count; no irq follows reset deassertion unless a new press is accepted.

Configuration
REQ-023 SHALL honor macro JOYPAD_DEBOUNCE_EN: defined -> REQ-011 debounce active; undefined -> stable equals synchronized level directly (press visible 2 cycles after input edge), counters and DEBOUNCE_CYCLES unused.

Structure
REQ-024 SHALL place P1 address constant (16'hFF00) and a button-index enum (A, B, SELECT, START, RIGHT, LEFT, UP, DOWN) in the shared GameBoy constants package.
REQ-025 SHALL implement synchronizer plus debounce for one button as sub-module joypad_debounce, instantiated 8 times.

Verification (bench uses DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-026 Reset, all buttons high, read FF00 -> data_out=8'hFF, joypad_irq=0.
REQ-027 Write 8'h20 (P14 selected), hold joypad_right low 10 cycles -> nibble bit0=0 after 2+4 cycles, data_out=8'hEE, one irq pulse next cycle.
REQ-028 joypad_a low with sel=2'b11, then write 8'h10 -> data_out=8'hDE, single irq pulse from select change.
REQ-029 joypad_b glitch low for 3 cycles then high -> no stable change, data_out unchanged, no irq.
REQ-030 Assert rst mid-debounce of joypad_start (2 of 4 cycles) -> outputs at reset values, no irq after release of rst.
REQ-031 Macro undefined, write 8'h20, joypad_up low -> data_out=8'hEB 2 cycles after input edge plus 1, irq pulse following.
